// File: rtl/mcpu_video_pkg.sv
// Shared video constants, fetch FSM state type and pixel-select helpers
// for the MCPU framebuffer scan-out path.
package mcpu_video_pkg;

   localparam int unsigned H_VISIBLE       = 256;
   localparam int unsigned WORDS_PER_LINE  = 16;
   localparam int unsigned PIX_PER_WORD    = 8;
   localparam logic [11:0] FB_BASE_DEFAULT = 12'h800;
   localparam logic [3:0]  BORDER_ON       = 4'hF;
   localparam logic [3:0]  BORDER_OFF      = 4'h0;

   typedef enum logic {
      F_IDLE,
      F_REQ
   } fetch_state_t;

   // Each logical pixel spans two raster columns, so hpos[3:1] picks the nibble.
   function automatic logic [2:0] nib_sel(input logic [8:0] hpos);
      return hpos[3:1];
   endfunction

   function automatic logic [3:0] pick_nibble(input logic [31:0] word, input logic [2:0] sel);
      return word[{sel, 2'b00} +: 4];
   endfunction

   function automatic logic [11:0] word_addr(input logic [11:0] base, input logic [6:0] row,
                                             input logic [3:0] col);
      return base + {1'b0, row, col};
   endfunction

endpackage

// File: rtl/mcpu_word_fifo.sv
// Two-entry 32-bit word FIFO between the fetch port and the pixel serialiser.
module mcpu_word_fifo (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  logic [31:0] din,
   output logic [1:0]  count,
   output logic [31:0] head
);

   logic [31:0] mem [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic        do_push;
   logic        do_pop;

   assign do_pop  = pop && (count != 2'd0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && ((count != 2'd2) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= !wr_ptr;
         end
         if (do_pop) rd_ptr <= !rd_ptr;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assert property (@(posedge clk) disable iff (!reset)
                    !(push && !flush && (count == 2'd2) && !pop));

endmodule

// File: rtl/mcpu_fb_scanout.sv
// Prefetching framebuffer scan-out: fetches 16 words per raster line pair
// over a req/ack port and serialises them into 2x-scaled 4-bit pixels.
module mcpu_fb_scanout
   import mcpu_video_pkg::*;
#(
   parameter logic [11:0] FB_BASE        = FB_BASE_DEFAULT,
   parameter int unsigned H_ARM          = 280,
   parameter int unsigned V_TOTAL        = 262,
   parameter int unsigned V_VISIBLE      = 240,
   parameter logic [3:0]  UNDERRUN_COLOR = 4'hC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [8:0]  hpos,
   input  logic [8:0]  vpos,
   input  logic        display_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic        fb_req,
   output logic [11:0] fb_addr,
   input  logic        fb_ack,
   input  logic [31:0] fb_data,
   output logic [3:0]  rgb,
   output logic        hsync,
   output logic        vsync,
   output logic        underrun,
   input  logic        clr_underrun
);

   localparam logic [8:0] ARM_POS = 9'(H_ARM);
   localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
   localparam logic [8:0] V_VIS   = 9'(V_VISIBLE);

   fetch_state_t state;
   logic [6:0]   row;
   logic [3:0]   col;
   logic [4:0]   words_left;
   logic         drop;
   logic [31:0]  w;

   logic [8:0]   next_v;
   logic         arm_vis;
   logic         push;
   logic         pop;
   logic         pop_eff;
   logic         push_eff;
   logic [1:0]   count;
   logic [1:0]   count_next;
   logic [31:0]  head;
   logic [3:0]   col_n;
   logic [4:0]   words_n;
   logic [3:0]   rgb_next;
   logic [31:0]  w_next;
   logic         set_underrun;

   assign next_v   = (vpos == V_LAST) ? '0 : vpos + 9'd1;
   assign arm_vis  = (hpos == ARM_POS) && (next_v < V_VIS);
   // Data of a request that straddles a flush is discarded on arrival.
   assign push     = fb_req && fb_ack && !drop && !arm_vis;
   assign pop_eff  = pop && (count != 2'd0);
   assign push_eff = push && ((count != 2'd2) || pop_eff);

   always_comb begin
      count_next = count + {1'b0, push_eff} - {1'b0, pop_eff};
      if (arm_vis) count_next = '0;
   end

   always_comb begin
      col_n   = col;
      words_n = words_left;
      if (!drop) begin
         col_n   = col + 4'd1;
         words_n = words_left - 5'd1;
      end
   end

   mcpu_word_fifo u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (arm_vis),
      .din   (fb_data),
      .count (count),
      .head  (head)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= F_IDLE;
         fb_req     <= 1'b0;
         fb_addr    <= '0;
         row        <= '0;
         col        <= '0;
         words_left <= '0;
         drop       <= 1'b0;
      end else if (arm_vis) begin
         row        <= next_v[7:1];
         col        <= '0;
         words_left <= 5'(WORDS_PER_LINE);
         if (fb_req && !fb_ack) begin
            drop <= 1'b1;
         end else begin
            drop   <= 1'b0;
            state  <= F_IDLE;
            fb_req <= 1'b0;
         end
      end else begin
         case (state)
            F_IDLE: begin
               if ((words_left != '0) && (count != 2'd2)) begin
                  state   <= F_REQ;
                  fb_req  <= 1'b1;
                  fb_addr <= word_addr(FB_BASE, row, col);
               end
            end
            F_REQ: begin
               if (fb_ack) begin
                  drop       <= 1'b0;
                  col        <= col_n;
                  words_left <= words_n;
                  if ((words_n != '0) && (count_next != 2'd2)) begin
                     fb_addr <= word_addr(FB_BASE, row, col_n);
                  end else begin
                     state  <= F_IDLE;
                     fb_req <= 1'b0;
                  end
               end
            end
            default: begin
               state  <= F_IDLE;
               fb_req <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      pop          = 1'b0;
      set_underrun = 1'b0;
      w_next       = w;
      rgb_next     = pick_nibble(w, nib_sel(hpos));
      if (!display_on) begin
         rgb_next = (hpos[0] ^ vpos[0]) ? BORDER_ON : BORDER_OFF;
      end else if (hpos[3:0] == 4'd0) begin
         pop = 1'b1;
         if (count != 2'd0) begin
            w_next   = head;
            rgb_next = pick_nibble(head, nib_sel(hpos));
         end else begin
            w_next       = {8{UNDERRUN_COLOR}};
            rgb_next     = UNDERRUN_COLOR;
            set_underrun = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w        <= '0;
         rgb      <= '0;
         hsync    <= 1'b0;
         vsync    <= 1'b0;
         underrun <= 1'b0;
      end else begin
         w     <= w_next;
         rgb   <= rgb_next;
         hsync <= hsync_in;
         vsync <= vsync_in;
         if (set_underrun)      underrun <= 1'b1;
         else if (clr_underrun) underrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mcpu_fb_scanout.sv
// Self-checking bench for mcpu_fb_scanout: RAM responder plus a queue-based
// pixel/underrun model, driven by directed and randomized raster lines.
module tb_mcpu_fb_scanout;

   logic        clk = 1'b0;
   logic        reset;
   logic [8:0]  hpos;
   logic [8:0]  vpos;
   logic        display_on;
   logic        hsync_in;
   logic        vsync_in;
   logic        fb_req;
   logic [11:0] fb_addr;
   logic        fb_ack;
   logic [31:0] fb_data;
   logic [3:0]  rgb;
   logic        hsync;
   logic        vsync;
   logic        underrun;
   logic        clr_underrun;

   always #5 clk = ~clk;

   mcpu_fb_scanout dut (
      .clk          (clk),
      .reset        (reset),
      .hpos         (hpos),
      .vpos         (vpos),
      .display_on   (display_on),
      .hsync_in     (hsync_in),
      .vsync_in     (vsync_in),
      .fb_req       (fb_req),
      .fb_addr      (fb_addr),
      .fb_ack       (fb_ack),
      .fb_data      (fb_data),
      .rgb          (rgb),
      .hsync        (hsync),
      .vsync        (vsync),
      .underrun     (underrun),
      .clr_underrun (clr_underrun)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [31:0] ram [4096];
   logic [31:0] mq[$];
   logic [11:0] acked[$];
   int unsigned ack_cyc[$];
   logic [31:0] mw;
   bit          mur;
   bit          mdrop;
   int unsigned wait_cnt;
   int unsigned base_delay;
   int unsigned slow_delay;
   logic [11:0] slow_addr;
   bit          rand_delay;
   int unsigned cyc;
   logic [3:0]  exp_rgb;
   logic        exp_hs;
   logic        exp_vs;

   task automatic model_reset();
      mq.delete();
      mw       = '0;
      mur      = 1'b0;
      mdrop    = 1'b0;
      wait_cnt = 0;
      fb_ack   = 1'b0;
   endtask

   task automatic drive(input logic [8:0] h, input logic [8:0] v, input bit d);
      hpos       = h;
      vpos       = v;
      display_on = d;
      hsync_in   = 1'($urandom_range(0, 1));
      vsync_in   = 1'($urandom_range(0, 1));
   endtask

   // RAM responder and reference model for one clock; ends #1 after the edge.
   task automatic tick();
      int unsigned d;
      int          k;
      logic [8:0]  nv;
      bit          armv;
      bit          ur;
      d = (fb_addr == slow_addr) ? slow_delay : base_delay;
      fb_ack  = fb_req && (wait_cnt >= d);
      fb_data = fb_ack ? ram[fb_addr] : $urandom;
      if (fb_ack) begin
         acked.push_back(fb_addr);
         ack_cyc.push_back(cyc);
      end
      ur = 1'b0;
      k  = int'(hpos % 16) / 2;
      if (!display_on) begin
         exp_rgb = (hpos[0] ^ vpos[0]) ? 4'hF : 4'h0;
      end else begin
         if (hpos % 16 == 0) begin
            if (mq.size() > 0) mw = mq.pop_front();
            else begin
               mw = {8{4'hC}};
               ur = 1'b1;
            end
         end
         exp_rgb = mw[k*4 +: 4];
      end
      if (ur) mur = 1'b1;
      else if (clr_underrun) mur = 1'b0;
      nv   = (vpos == 9'd261) ? 9'd0 : vpos + 9'd1;
      armv = (hpos == 9'd280) && (nv < 9'd240);
      if (armv) begin
         mq.delete();
         mdrop = fb_req && !fb_ack;
      end else if (fb_ack) begin
         if (!mdrop) mq.push_back(fb_data);
         mdrop = 1'b0;
      end
      exp_hs = hsync_in;
      exp_vs = vsync_in;
      if (fb_ack) begin
         wait_cnt = 0;
         if (rand_delay) base_delay = $urandom_range(0, 12);
      end else if (fb_req) begin
         wait_cnt++;
      end
      @(posedge clk);
      #1;
      cyc++;
      fb_ack = 1'b0;
   endtask

   task automatic test_reset();
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (rgb !== 4'h0) begin n_bad++; $display("FAIL reset_rgb: got %h want 0", rgb); end
      n_cmp++; if (fb_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", fb_req); end
      n_cmp++; if (fb_addr !== 12'h000) begin n_bad++; $display("FAIL reset_addr: got %h want 000", fb_addr); end
      n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      n_cmp++; if (hsync !== 1'b0 || vsync !== 1'b0) begin n_bad++; $display("FAIL reset_sync: got %b%b want 00", hsync, vsync); end
      reset = 1'b1;
      model_reset();
      drive(9'd0, 9'd20, 1'b1);
      tick();
      n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL first_underrun: got %b want 1", underrun); end
      n_cmp++; if (rgb !== 4'hC) begin n_bad++; $display("FAIL first_underrun_rgb: got %h want C", rgb); end
      base_delay = 50;
      drive(9'd280, 9'd9, 1'b0);
      tick();
      for (int h = 281; h < 284; h++) begin
         drive(9'(h), 9'd9, 1'b0);
         tick();
      end
      n_cmp++; if (fb_req !== 1'b1) begin n_bad++; $display("FAIL pre_reset_req: got %b want 1", fb_req); end
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (fb_req !== 1'b0) begin n_bad++; $display("FAIL midline_reset_req: got %b want 0", fb_req); end
      n_cmp++; if (rgb !== 4'h0) begin n_bad++; $display("FAIL midline_reset_rgb: got %h want 0", rgb); end
      n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL midline_reset_underrun: got %b want 0", underrun); end
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      base_delay = 0;
      for (int h = 284; h < 340; h++) begin
         drive(9'(h % 300), 9'd9, 1'b0);
         tick();
         n_cmp++; if (fb_req !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle h=%0d: got %b want 0", h % 300, fb_req); end
      end
   endtask

   task automatic test_fetch();
      int unsigned gap;
      acked.delete();
      ack_cyc.delete();
      base_delay = 0;
      ram[12'h850] = 32'h76543210;
      drive(9'd280, 9'd9, 1'b0);
      tick();
      for (int h = 281; h < 300; h++) begin
         drive(9'(h), 9'd9, 1'b0);
         tick();
         n_cmp++; if (rgb !== exp_rgb) begin n_bad++; $display("FAIL fetch_border h=%0d: got %h want %h", h, rgb, exp_rgb); end
      end
      n_cmp++; if (acked.size() != 2) begin n_bad++; $display("FAIL fifo_block_count: got %0d want 2", acked.size()); end
      n_cmp++; if (fb_req !== 1'b0) begin n_bad++; $display("FAIL fifo_block_req: got %b want 0", fb_req); end
      if (acked.size() >= 2) begin
         n_cmp++; if (acked[0] !== 12'h850) begin n_bad++; $display("FAIL first_addr: got %h want 850", acked[0]); end
         gap = ack_cyc[1] - ack_cyc[0];
         n_cmp++; if (gap != 1) begin n_bad++; $display("FAIL back_to_back_gap: got %0d want 1", gap); end
      end
      for (int h = 0; h < 256; h++) begin
         drive(9'(h), 9'd10, 1'b1);
         tick();
         n_cmp++; if (rgb !== exp_rgb) begin n_bad++; $display("FAIL fetch_pix h=%0d: got %h want %h", h, rgb, exp_rgb); end
         if (h < 16) begin
            n_cmp++; if (rgb !== 4'(h / 2)) begin n_bad++; $display("FAIL word0_pix h=%0d: got %h want %h", h, rgb, 4'(h / 2)); end
         end
      end
      for (int h = 256; h < 280; h++) begin
         drive(9'(h), 9'd10, 1'b0);
         tick();
      end
      n_cmp++; if (acked.size() != 16) begin n_bad++; $display("FAIL fetch_total: got %0d want 16", acked.size()); end
      for (int i = 0; i < acked.size(); i++) begin
         n_cmp++; if (acked[i] !== 12'(12'h850 + i)) begin n_bad++; $display("FAIL fetch_addr[%0d]: got %h want %h", i, acked[i], 12'(12'h850 + i)); end
      end
   endtask

   task automatic test_underrun();
      acked.delete();
      slow_addr  = 12'h8A1;
      slow_delay = 20;
      drive(9'd280, 9'd19, 1'b0);
      tick();
      for (int h = 281; h < 284; h++) begin
         drive(9'(h), 9'd19, 1'b0);
         tick();
      end
      for (int h = 0; h < 256; h++) begin
         drive(9'(h), 9'd20, 1'b1);
         clr_underrun = (h == 40);
         tick();
         n_cmp++; if (rgb !== exp_rgb) begin n_bad++; $display("FAIL underrun_pix h=%0d: got %h want %h", h, rgb, exp_rgb); end
         if (h >= 16 && h < 32) begin
            n_cmp++; if (rgb !== 4'hC) begin n_bad++; $display("FAIL underrun_color h=%0d: got %h want C", h, rgb); end
         end
         if (h == 16) begin
            n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL underrun_set: got %b want 1", underrun); end
         end
         if (h == 40) begin
            n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL underrun_clear: got %b want 0", underrun); end
         end
      end
      clr_underrun = 1'b0;
      slow_delay   = 0;
      slow_addr    = 12'hFFF;
      drive(9'd0, 9'd21, 1'b1);
      tick();
      n_cmp++; if (underrun !== mur) begin n_bad++; $display("FAIL leftover_pop_flag: got %b want %b", underrun, mur); end
      drive(9'd0, 9'd21, 1'b1);
      clr_underrun = 1'b1;
      tick();
      n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL set_beats_clear: got %b want 1", underrun); end
      drive(9'd1, 9'd21, 1'b0);
      tick();
      n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL clear_after: got %b want 0", underrun); end
      clr_underrun = 1'b0;
   endtask

   task automatic test_checker();
      drive(9'd3, 9'd4, 1'b0);
      tick();
      n_cmp++; if (rgb !== 4'hF) begin n_bad++; $display("FAIL checker_odd: got %h want F", rgb); end
      n_cmp++; if (hsync !== exp_hs || vsync !== exp_vs) begin n_bad++; $display("FAIL sync_delay: got %b%b want %b%b", hsync, vsync, exp_hs, exp_vs); end
      drive(9'd3, 9'd5, 1'b0);
      tick();
      n_cmp++; if (rgb !== 4'h0) begin n_bad++; $display("FAIL checker_even: got %h want 0", rgb); end
      n_cmp++; if (hsync !== exp_hs || vsync !== exp_vs) begin n_bad++; $display("FAIL sync_delay2: got %b%b want %b%b", hsync, vsync, exp_hs, exp_vs); end
   endtask

   task automatic test_wrap();
      int unsigned req_seen;
      acked.delete();
      drive(9'd280, 9'd261, 1'b0);
      tick();
      for (int h = 281; h < 300; h++) begin
         drive(9'(h), 9'd261, 1'b0);
         tick();
      end
      n_cmp++; if (acked.size() == 0 || acked[0] !== 12'h800) begin n_bad++; $display("FAIL wrap_addr: got %h want 800", acked.size() ? acked[0] : 12'hXXX); end
      for (int h = 0; h < 256; h++) begin
         drive(9'(h), 9'd0, 1'b1);
         tick();
         n_cmp++; if (rgb !== exp_rgb) begin n_bad++; $display("FAIL wrap_pix h=%0d: got %h want %h", h, rgb, exp_rgb); end
      end
      for (int h = 256; h < 280; h++) begin
         drive(9'(h), 9'd0, 1'b0);
         tick();
      end
      n_cmp++; if (acked.size() != 16) begin n_bad++; $display("FAIL wrap_total: got %0d want 16", acked.size()); end
      acked.delete();
      req_seen = 0;
      for (int h = 280; h < 280 + 300; h++) begin
         drive(9'(h % 300), (h < 300) ? 9'd239 : 9'd240, 1'b0);
         tick();
         if (fb_req) req_seen++;
      end
      n_cmp++; if (req_seen != 0) begin n_bad++; $display("FAIL invisible_req: got %0d cycles want 0", req_seen); end
      n_cmp++; if (acked.size() != 0) begin n_bad++; $display("FAIL invisible_acks: got %0d want 0", acked.size()); end
   endtask

   task automatic test_rearm();
      acked.delete();
      base_delay = 3;
      drive(9'd280, 9'd9, 1'b0);
      tick();
      drive(9'd281, 9'd9, 1'b0);
      tick();
      drive(9'd282, 9'd9, 1'b0);
      tick();
      n_cmp++; if (fb_req !== 1'b1) begin n_bad++; $display("FAIL rearm_pending: got %b want 1", fb_req); end
      drive(9'd280, 9'd29, 1'b0);
      tick();
      for (int h = 281; h < 300; h++) begin
         drive(9'(h), 9'd29, 1'b0);
         tick();
      end
      for (int h = 0; h < 256; h++) begin
         drive(9'(h), 9'd30, 1'b1);
         tick();
         n_cmp++; if (rgb !== exp_rgb) begin n_bad++; $display("FAIL rearm_pix h=%0d: got %h want %h", h, rgb, exp_rgb); end
      end
      for (int h = 256; h < 280; h++) begin
         drive(9'(h), 9'd30, 1'b0);
         tick();
      end
      n_cmp++; if (acked.size() != 17) begin n_bad++; $display("FAIL rearm_total: got %0d want 17", acked.size()); end
      if (acked.size() >= 2) begin
         n_cmp++; if (acked[0] !== 12'h850) begin n_bad++; $display("FAIL rearm_old: got %h want 850", acked[0]); end
         n_cmp++; if (acked[1] !== 12'h8F0) begin n_bad++; $display("FAIL rearm_new: got %h want 8F0", acked[1]); end
         n_cmp++; if (acked[acked.size()-1] !== 12'h8FF) begin n_bad++; $display("FAIL rearm_last: got %h want 8FF", acked[acked.size()-1]); end
      end
      base_delay = 0;
   endtask

   task automatic test_random();
      logic [8:0]  v;
      logic [11:0] first;
      rand_delay = 1'b1;
      repeat (6) begin
         v     = 9'($urandom_range(0, 237));
         first = 12'(12'h800 + ((v + 1) / 2) * 16);
         acked.delete();
         drive(9'd280, v, 1'b0);
         tick();
         for (int h = 281; h < 300; h++) begin
            drive(9'(h), v, 1'b0);
            tick();
         end
         for (int h = 0; h < 280; h++) begin
            drive(9'(h), v + 9'd1, h < 256);
            clr_underrun = ($urandom_range(0, 15) == 0);
            tick();
            n_cmp++; if (rgb !== exp_rgb) begin n_bad++; $display("FAIL rand_pix v=%0d h=%0d: got %h want %h", v + 1, h, rgb, exp_rgb); end
            n_cmp++; if (underrun !== mur) begin n_bad++; $display("FAIL rand_underrun v=%0d h=%0d: got %b want %b", v + 1, h, underrun, mur); end
            n_cmp++; if (fb_req && mq.size() >= 2) begin n_bad++; $display("FAIL rand_overfetch h=%0d: req with %0d buffered want <2", h, mq.size()); end
         end
         clr_underrun = 1'b0;
         n_cmp++; if (acked.size() != 16) begin n_bad++; $display("FAIL rand_total v=%0d: got %0d want 16", v, acked.size()); end
         for (int i = 0; i < acked.size(); i++) begin
            n_cmp++; if (acked[i] !== 12'(first + i)) begin n_bad++; $display("FAIL rand_addr[%0d]: got %h want %h", i, acked[i], 12'(first + i)); end
         end
      end
      rand_delay = 1'b0;
      base_delay = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b0;
      hpos         = '0;
      vpos         = '0;
      display_on   = 1'b0;
      hsync_in     = 1'b0;
      vsync_in     = 1'b0;
      fb_ack       = 1'b0;
      fb_data      = '0;
      clr_underrun = 1'b0;
      base_delay   = 0;
      slow_delay   = 0;
      slow_addr    = 12'hFFF;
      rand_delay   = 1'b0;
      cyc          = 0;
      for (int i = 0; i < 4096; i++) ram[i] = $urandom;
      model_reset();
      test_reset();
      test_fetch();
      test_underrun();
      test_checker();
      test_wrap();
      test_rearm();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
